// File: rtl/spdif_sample_fifo.sv
// Stereo sample FIFO feeding the SPDIF TX encoder: one prefetched frame is held on
// audio_l/audio_r and replaced on each encoder ack; starvation is flagged and counted.
module spdif_sample_fifo #(
    parameter int unsigned DEPTH_LOG2 = 8,
    parameter int unsigned LOW_THRESH = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [23:0]           wr_l,
    input  logic [23:0]           wr_r,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic                  flush,
    output logic [23:0]           audio_l,
    output logic [23:0]           audio_r,
    output logic                  audio_valid,
    input  logic                  ack,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  low_lvl,
    output logic                  underrun,
    output logic [15:0]           urun_cnt
);
    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned PW    = DEPTH_LOG2 + 1;

    typedef enum logic [1:0] {StIdle, StRead, StHold} state_e;

    logic [47:0]   mem [DEPTH];
    logic [47:0]   rd_data_q;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, level_q, level_d;
    state_e        state_q, state_d;
    logic          out_fresh_q, out_fresh_d;
    logic [23:0]   out_l_q, out_l_d, out_r_q, out_r_d;
    logic          low_lvl_q, low_lvl_d, underrun_q, underrun_d;
    logic [15:0]   urun_cnt_q, urun_cnt_d;
    logic          full, empty, push, rd_en;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                   (wr_ptr_q[DEPTH_LOG2-1:0] == rd_ptr_q[DEPTH_LOG2-1:0]);
    assign push  = wr_valid && !full && !flush;

    always_comb begin
        state_d     = state_q;
        out_fresh_d = out_fresh_q;
        out_l_d     = out_l_q;
        out_r_d     = out_r_q;
        underrun_d  = 1'b0;
        urun_cnt_d  = urun_cnt_q;
        rd_en       = 1'b0;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q + PW'(push);

        unique case (state_q)
            StIdle: begin
                if (!empty) begin
                    rd_en    = 1'b1;
                    rd_ptr_d = rd_ptr_q + PW'(1);
                    state_d  = StRead;
                end
            end
            StRead: begin
                out_l_d     = rd_data_q[47:24];
                out_r_d     = rd_data_q[23:0];
                out_fresh_d = 1'b1;
                state_d     = StHold;
            end
            StHold: begin
                if (ack) begin
                    out_fresh_d = 1'b0;
                    out_l_d     = '0;
                    out_r_d     = '0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // Encoder consumed a frame we never delivered: count it, leave the FSM alone.
        if (ack && !out_fresh_q) begin
            underrun_d = 1'b1;
            if (urun_cnt_q != 16'hffff) urun_cnt_d = urun_cnt_q + 16'd1;
        end

        if (flush) begin
            state_d     = StIdle;
            out_fresh_d = 1'b0;
            out_l_d     = '0;
            out_r_d     = '0;
            underrun_d  = 1'b0;
            urun_cnt_d  = '0;
            rd_en       = 1'b0;
            rd_ptr_d    = '0;
            wr_ptr_d    = '0;
        end

        level_d   = wr_ptr_d - rd_ptr_d;
        low_lvl_d = (32'(level_d) < LOW_THRESH);
    end

    // RAM array carries no reset; pointers alone define its contents.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q[DEPTH_LOG2-1:0]] <= {wr_l, wr_r};
        if (rd_en) rd_data_q <= mem[rd_ptr_q[DEPTH_LOG2-1:0]];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            out_fresh_q <= 1'b0;
            out_l_q     <= '0;
            out_r_q     <= '0;
            low_lvl_q   <= (LOW_THRESH > 0);
            underrun_q  <= 1'b0;
            urun_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            out_fresh_q <= out_fresh_d;
            out_l_q     <= out_l_d;
            out_r_q     <= out_r_d;
            low_lvl_q   <= low_lvl_d;
            underrun_q  <= underrun_d;
            urun_cnt_q  <= urun_cnt_d;
        end
    end

    assign wr_ready    = !full;
    assign audio_l     = out_l_q;
    assign audio_r     = out_r_q;
    assign audio_valid = out_fresh_q;
    assign level       = level_q;
    assign low_lvl     = low_lvl_q;
    assign underrun    = underrun_q;
    assign urun_cnt    = urun_cnt_q;

endmodule
